// File: rtl/router_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter_if
// Purpose  : Router FIFO drain bus plus the shared output byte handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface router_out_arbiter_if;
    logic [2:0] vldout;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic [2:0] read_enb;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_chan;
    logic       out_ready;

    modport master (
        input  vldout, data_out_0, data_out_1, data_out_2, out_ready,
        output read_enb, out_valid, out_data, out_chan
    );

    modport slave (
        output vldout, data_out_0, data_out_1, data_out_2, out_ready,
        input  read_enb, out_valid, out_data, out_chan
    );
endinterface
`default_nettype wire

// File: rtl/router_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_out_arbiter
// Purpose  : Round-robin drain of three router FIFOs onto one tagged byte port.
// Revision : 1.0 - initial release
// ============================================================================
module router_out_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  wire                 clk,
    input  wire                 rst_n,
    router_out_arbiter_if.master bus,
    input  wire  [2:0]          ch_en,
    output logic [2:0]          gnt,
    output logic [CNT_W-1:0]    xfer_cnt
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_serve  = 1'b1;
    localparam logic [2:0] c_burst_max = 3'(BURST_MAX);

    logic [0:0]       r_state;
    logic [1:0]       r_gch;
    logic [1:0]       r_last;
    logic [2:0]       r_burst_cnt;
    logic [2:0]       r_gnt;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic [1:0]       r_out_chan;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic [2:0] w_elig;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic [1:0] w_pick;
    logic [2:0] w_gch_oh;
    logic       w_gch_elig;
    logic       w_load;
    logic [7:0] w_head;
    logic [2:0] w_burst_nxt;

    function automatic logic [1:0] f_next3(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    assign w_elig      = bus.vldout & ch_en;
    assign w_cand1     = f_next3(r_last);
    assign w_cand2     = f_next3(w_cand1);
    assign w_gch_oh    = 3'b001 << r_gch;
    assign w_gch_elig  = |(w_elig & w_gch_oh);
    assign w_burst_nxt = r_burst_cnt + 3'd1;

    // Backpressure only blocks when the held byte is not being taken this cycle.
    assign w_load = (r_state == c_st_serve) && w_gch_elig && (!r_out_valid || bus.out_ready);

    // Search wraps past the last served channel so it gets lowest priority.
    always_comb begin
        w_pick = r_last;
        if (|(w_elig & (3'b001 << w_cand1))) begin
            w_pick = w_cand1;
        end else if (|(w_elig & (3'b001 << w_cand2))) begin
            w_pick = w_cand2;
        end
    end

    always_comb begin
        case (r_gch)
            2'd0:    w_head = bus.data_out_0;
            2'd1:    w_head = bus.data_out_1;
            default: w_head = bus.data_out_2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_gch       <= 2'd0;
            r_last      <= 2'd2;
            r_burst_cnt <= 3'd0;
            r_gnt       <= 3'b000;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_chan  <= 2'd0;
            r_xfer_cnt  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_elig) begin
                        r_state     <= c_st_serve;
                        r_gch       <= w_pick;
                        r_gnt       <= 3'b001 << w_pick;
                        r_burst_cnt <= 3'd0;
                    end
                end
                c_st_serve: begin
                    if (!w_gch_elig) begin
                        r_state <= c_st_idle;
                        r_last  <= r_gch;
                        r_gnt   <= 3'b000;
                    end else if (w_load) begin
                        r_burst_cnt <= w_burst_nxt;
                        if (w_burst_nxt == c_burst_max) begin
                            r_state <= c_st_idle;
                            r_last  <= r_gch;
                            r_gnt   <= 3'b000;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_gnt   <= 3'b000;
                end
            endcase

            if (w_load) begin
                r_out_data  <= w_head;
                r_out_chan  <= r_gch;
                r_out_valid <= 1'b1;
                r_xfer_cnt  <= r_xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.read_enb  = w_load ? w_gch_oh : 3'b000;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign gnt           = r_gnt;
    assign xfer_cnt      = r_xfer_cnt;

endmodule
`default_nettype wire
